branch_predictor: RTL and testbench

Dynamic branch predictor for the five-stage RISC-V pipeline. Looks up the fetch PC in the IF stage and supplies a predicted next PC. In EX it consumes the branch decision (BranchE) and the computed target from the branch comparator, trains its tables, and flags mispredictions for the hazard unit. It also keeps branch and misprediction statistics.

---
 rtl/branch_predictor_pkg.sv | 21 ++
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor_bht_counter.sv | 20 ++
 rtl/branch_predictor.sv | 147 ++++++++++++++
 tb/tb_branch_predictor.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: branch-type encodings and 2-bit counter states.
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-side bundle of the branch predictor: IF lookup, EX resolve/train, statistics.
interface branch_predictor_if;

  logic [31:0]                    PCF;
  logic                           PredTakenF;
  logic [31:0]                    PredTargetF;

  logic                           ValidE;
  logic [31:0]                    PCE;
  branch_predictor_pkg::br_type_e BranchTypeE;
  logic                           BranchE;
  logic [31:0]                    BrTargetE;
  logic                           PredTakenE;
  logic [31:0]                    PredTargetE;
  logic                           MispredE;
  logic [31:0]                    RecoverPCE;

  logic [31:0]                    BranchCnt;
  logic [31:0]                    MispredCnt;

  modport master (
    output PCF, ValidE, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredE, RecoverPCE, BranchCnt, MispredCnt
  );

  modport slave (
    input  PCF, ValidE, PCE, BranchTypeE, BranchE, BrTargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredE, RecoverPCE, BranchCnt, MispredCnt
  );

endinterface

// File: rtl/branch_predictor_bht_counter.sv
// bht_counter: combinational next state of a 2-bit saturating taken/not-taken counter.
module bht_counter
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  // NOTE: assign the output a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_e'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with optional 2-bit BHT; define BRANCH_PREDICTOR_BHT_EN for counters,
// leave undefined for BTB-only prediction (taken whenever the entry hits).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 64
) (
  input logic              CLK,
  input logic              CpuRst,
  branch_predictor_if.slave bp
);

  localparam int IDX   = $clog2(ENTRY_NUM);
  localparam int TAG_W = 30 - IDX;

  typedef logic [IDX-1:0]   idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  logic        valid_q  [ENTRY_NUM];
  tag_t        tag_q    [ENTRY_NUM];
  logic [31:0] target_q [ENTRY_NUM];
`ifdef BRANCH_PREDICTOR_BHT_EN
  ctr_e        ctr_q    [ENTRY_NUM];
  ctr_e        ctr_next;
  logic        ctr_we;
  ctr_e        ctr_d;
`endif

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  idx_t idx_f, idx_e;
  tag_t tag_f, tag_e;
  logic hit_f, hit_e, is_branch, upd, mispred;
  logic valid_we, valid_d, data_we;
  logic unused_pcf_lsb;

  assign idx_f = bp.PCF[IDX+1:2];
  assign tag_f = bp.PCF[31:IDX+2];
  assign idx_e = bp.PCE[IDX+1:2];
  assign tag_e = bp.PCE[31:IDX+2];
  assign unused_pcf_lsb = ^bp.PCF[1:0];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

`ifdef BRANCH_PREDICTOR_BHT_EN
  assign bp.PredTakenF = hit_f && ctr_q[idx_f][1];
`else
  assign bp.PredTakenF = hit_f;
`endif
  assign bp.PredTargetF = bp.PredTakenF ? target_q[idx_f] : 32'h0;

  assign is_branch = (bp.BranchTypeE != NOBRANCH);
  assign upd       = bp.ValidE && is_branch;

  always_comb begin
    mispred = 1'b0;
    if (bp.ValidE) begin
      if (is_branch)
        mispred = (bp.BranchE != bp.PredTakenE) ||
                  (bp.BranchE && bp.PredTakenE && (bp.PredTargetE != bp.BrTargetE));
      else
        mispred = bp.PredTakenE;
    end
  end

  assign bp.MispredE   = mispred;
  assign bp.RecoverPCE = bp.BranchE ? bp.BrTargetE : bp.PCE + 32'd4;

`ifdef BRANCH_PREDICTOR_BHT_EN
  bht_counter u_bht_counter (
    .ctr_i   (ctr_q[idx_e]),
    .taken_i (bp.BranchE),
    .ctr_o   (ctr_next)
  );
`endif

  // Per-update write decision for the single EX-indexed entry.
  always_comb begin
    valid_we = 1'b0;
    valid_d  = 1'b0;
    data_we  = upd && bp.BranchE;
`ifdef BRANCH_PREDICTOR_BHT_EN
    ctr_we   = 1'b0;
    ctr_d    = WNT;
    if (upd) begin
      if (hit_e) begin
        ctr_we = 1'b1;
        ctr_d  = ctr_next;
      end else if (bp.BranchE) begin
        valid_we = 1'b1;
        valid_d  = 1'b1;
        ctr_we   = 1'b1;
        ctr_d    = WT;
      end
    end
`else
    if (upd) begin
      if (hit_e && !bp.BranchE) begin
        valid_we = 1'b1;
        valid_d  = 1'b0;
      end else if (!hit_e && bp.BranchE) begin
        valid_we = 1'b1;
        valid_d  = 1'b1;
      end
    end
`endif
  end

  assign branch_cnt_d  = branch_cnt_q + {31'b0, upd};
  assign mispred_cnt_d = mispred_cnt_q + {31'b0, mispred};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge CpuRst) begin
    if (CpuRst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i] <= 1'b0;
`ifdef BRANCH_PREDICTOR_BHT_EN
        ctr_q[i]   <= WNT;
`endif
      end
      branch_cnt_q  <= 32'h0;
      mispred_cnt_q <= 32'h0;
    end else begin
      if (valid_we) valid_q[idx_e] <= valid_d;
`ifdef BRANCH_PREDICTOR_BHT_EN
      if (ctr_we) ctr_q[idx_e] <= ctr_d;
`endif
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // NOTE: tags and targets are never read without a set valid bit, so this array has no reset.
  always_ff @(posedge CLK) begin
    if (data_we) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= bp.BrTargetE;
    end
  end

  assign bp.BranchCnt  = branch_cnt_q;
  assign bp.MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (ENTRY_NUM=64); follows BRANCH_PREDICTOR_BHT_EN.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRY_NUM(64)) dut (
    .CLK    (clk),
    .CpuRst (rst),
    .bp     (bp_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic want(input string tag, input logic [31:0] v);
    sb.push_back('{tag: tag, val: v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic exp_f(input string t, input logic pt, input logic [31:0] tgt);
    want({t, "_PredTakenF"}, {31'b0, pt});
    want({t, "_PredTargetF"}, tgt);
  endtask

  task automatic obs_f();
    check({31'b0, bp_if.PredTakenF});
    check(bp_if.PredTargetF);
  endtask

  task automatic exp_cnt(input string t, input logic [31:0] b, input logic [31:0] m);
    want({t, "_BranchCnt"}, b);
    want({t, "_MispredCnt"}, m);
  endtask

  task automatic obs_cnt();
    check(bp_if.BranchCnt);
    check(bp_if.MispredCnt);
  endtask

  task automatic exp_ex(input string t, input logic m, input logic [31:0] rec);
    want({t, "_MispredE"}, {31'b0, m});
    want({t, "_RecoverPCE"}, rec);
  endtask

  task automatic obs_ex();
    check({31'b0, bp_if.MispredE});
    check(bp_if.RecoverPCE);
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pce, input br_type_e t,
                          input logic br, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
    bp_if.ValidE      = v;
    bp_if.PCE         = pce;
    bp_if.BranchTypeE = t;
    bp_if.BranchE     = br;
    bp_if.BrTargetE   = tgt;
    bp_if.PredTakenE  = pt;
    bp_if.PredTargetE = ptgt;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bp_if.PCF = 32'h0;
    idle_ex();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    bp_if.PCF = 32'h0000_1000;
    exp_f("reset", 1'b0, 32'h0);
    exp_cnt("reset", 32'd0, 32'd0);
    #1;
    obs_f();
    obs_cnt();

    // First taken BEQ: miss, allocate; same-cycle lookup sees old contents
    drive_ex(1'b1, 32'h1000, BEQ, 1'b1, 32'h1040, 1'b0, 32'h0);
    exp_ex("beq_taken", 1'b1, 32'h1040);
    exp_f("no_bypass", 1'b0, 32'h0);
    #1;
    obs_ex();
    obs_f();
    step();
    idle_ex();
    exp_f("alloc", 1'b1, 32'h1040);
    exp_cnt("alloc", 32'd1, 32'd1);
    #1;
    obs_f();
    obs_cnt();

    // Not-taken twice
    drive_ex(1'b1, 32'h1000, BEQ, 1'b0, 32'h1040, 1'b1, 32'h1040);
    exp_ex("nt1", 1'b1, 32'h1004);
    #1;
    obs_ex();
    step();
    exp_f("nt1", 1'b0, 32'h0);
    exp_cnt("nt1", 32'd2, 32'd2);
    #1;
    obs_f();
    obs_cnt();

    drive_ex(1'b1, 32'h1000, BEQ, 1'b0, 32'h1040, 1'b0, 32'h0);
    exp_ex("nt2", 1'b0, 32'h1004);
    #1;
    obs_ex();
    step();
    exp_f("nt2", 1'b0, 32'h0);
    exp_cnt("nt2", 32'd3, 32'd2);
    #1;
    obs_f();
    obs_cnt();

    // Taken again: BHT climbs 00->01 (still not taken); BTB-only re-allocates
    drive_ex(1'b1, 32'h1000, BEQ, 1'b1, 32'h1080, 1'b0, 32'h0);
    exp_ex("t_after_nt", 1'b1, 32'h1080);
    #1;
    obs_ex();
    step();
`ifdef BRANCH_PREDICTOR_BHT_EN
    exp_f("t_after_nt", 1'b0, 32'h0);
`else
    exp_f("t_after_nt", 1'b1, 32'h1080);
`endif
    exp_cnt("t_after_nt", 32'd4, 32'd3);
    #1;
    obs_f();
    obs_cnt();

    // Correctly predicted taken
    drive_ex(1'b1, 32'h1000, BEQ, 1'b1, 32'h1080, 1'b1, 32'h1080);
    exp_ex("t_correct", 1'b0, 32'h1080);
    #1;
    obs_ex();
    step();
    exp_f("t_correct", 1'b1, 32'h1080);
    exp_cnt("t_correct", 32'd5, 32'd3);
    #1;
    obs_f();
    obs_cnt();

    // Taken with wrong predicted target
    drive_ex(1'b1, 32'h1000, BEQ, 1'b1, 32'h10C0, 1'b1, 32'h1080);
    exp_ex("tgt_wrong", 1'b1, 32'h10C0);
    #1;
    obs_ex();
    step();
    exp_f("tgt_wrong", 1'b1, 32'h10C0);
    exp_cnt("tgt_wrong", 32'd6, 32'd4);
    #1;
    obs_f();
    obs_cnt();

    // Alias: 0x1000 + 4*64 replaces the 0x1000 entry
    drive_ex(1'b1, 32'h1100, BNE, 1'b1, 32'h2200, 1'b0, 32'h0);
    exp_ex("alias", 1'b1, 32'h2200);
    #1;
    obs_ex();
    step();
    idle_ex();
    exp_f("alias_old", 1'b0, 32'h0);
    #1;
    obs_f();
    bp_if.PCF = 32'h1100;
    exp_f("alias_new", 1'b1, 32'h2200);
    exp_cnt("alias", 32'd7, 32'd5);
    #1;
    obs_f();
    obs_cnt();

    // Non-branch predicted taken
    drive_ex(1'b1, 32'h2000, NOBRANCH, 1'b0, 32'h0, 1'b1, 32'h3000);
    exp_ex("nonbr", 1'b1, 32'h2004);
    #1;
    obs_ex();
    step();
    idle_ex();
    exp_f("nonbr_keep", 1'b1, 32'h2200);
    exp_cnt("nonbr", 32'd7, 32'd6);
    #1;
    obs_f();
    obs_cnt();
    bp_if.PCF = 32'h2000;
    exp_f("nonbr_noalloc", 1'b0, 32'h0);
    #1;
    obs_f();

    // ValidE low gates misprediction
    drive_ex(1'b0, 32'h2000, NOBRANCH, 1'b0, 32'h0, 1'b1, 32'h3000);
    want("gated_MispredE", 32'd0);
    #1;
    check({31'b0, bp_if.MispredE});
    step();
    exp_cnt("gated", 32'd7, 32'd6);
    #1;
    obs_cnt();

    // MispredCnt wrap
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    want("preload_MispredCnt", 32'hFFFF_FFFF);
    #1;
    check(bp_if.MispredCnt);
    drive_ex(1'b1, 32'h2000, NOBRANCH, 1'b0, 32'h0, 1'b1, 32'h3000);
    step();
    idle_ex();
    exp_cnt("wrap", 32'd7, 32'd0);
    #1;
    obs_cnt();

    // Asynchronous reset in the middle of an update cycle
    drive_ex(1'b1, 32'h3000, BNE, 1'b1, 32'h3300, 1'b0, 32'h0);
    bp_if.PCF = 32'h1100;
    exp_f("pre_rst", 1'b1, 32'h2200);
    #1;
    obs_f();
    #1;
    rst = 1'b1;
    exp_f("async_rst", 1'b0, 32'h0);
    exp_cnt("async_rst", 32'd0, 32'd0);
    #1;
    obs_f();
    obs_cnt();
    step();
    bp_if.PCF = 32'h3000;
    exp_f("rst_blocks_upd", 1'b0, 32'h0);
    #1;
    obs_f();
    rst = 1'b0;
    idle_ex();
    step();
    exp_f("post_rst", 1'b0, 32'h0);
    exp_cnt("post_rst", 32'd0, 32'd0);
    #1;
    obs_f();
    obs_cnt();

    if (sb.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
